// File: rtl/up_down_pkg.sv
// Shared widths and seven-segment patterns for the up/down counter.
// Patterns are active-low, bit0 = a through bit6 = g.
package up_down_pkg;

   localparam int unsigned COUNT_W = 4;
   localparam int unsigned SEG_W   = 7;

   localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
   localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
   localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
   localparam logic [SEG_W-1:0] SEG_A = 7'h08;
   localparam logic [SEG_W-1:0] SEG_B = 7'h03;
   localparam logic [SEG_W-1:0] SEG_C = 7'h46;
   localparam logic [SEG_W-1:0] SEG_D = 7'h21;
   localparam logic [SEG_W-1:0] SEG_E = 7'h06;
   localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
// Reusable for any display digit.
module hex_to_7seg
   import up_down_pkg::*;
(
   input  logic [COUNT_W-1:0] hex,
   output logic [SEG_W-1:0]   seg
);

   always_comb begin
      seg = SEG_BLANK;
      unique case (hex)
         4'h0:    seg = SEG_0;
         4'h1:    seg = SEG_1;
         4'h2:    seg = SEG_2;
         4'h3:    seg = SEG_3;
         4'h4:    seg = SEG_4;
         4'h5:    seg = SEG_5;
         4'h6:    seg = SEG_6;
         4'h7:    seg = SEG_7;
         4'h8:    seg = SEG_8;
         4'h9:    seg = SEG_9;
         4'hA:    seg = SEG_A;
         4'hB:    seg = SEG_B;
         4'hC:    seg = SEG_C;
         4'hD:    seg = SEG_D;
         4'hE:    seg = SEG_E;
         4'hF:    seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/up_down_counter.sv
// 4-bit wrap-around up/down counter with pause and prescaled tick,
// driving one hex seven-segment digit.
module up_down_counter
   import up_down_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             up_down,
   input  logic             pause,
   output logic [SEG_W-1:0] hex_out
);

   localparam int unsigned PRE_W =
      (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0]   pre;
   logic               tick;
   logic [COUNT_W-1:0] count;

   assign tick = (pre == PRE_MAX);

   // Prescaler free-runs; pause only gates the count update.
   always_ff @(posedge clk) begin
      if (reset)
         pre <= '0;
      else if (tick)
         pre <= '0;
      else
         pre <= pre + PRE_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (tick && !pause)
         count <= up_down ? count + COUNT_W'(1)
                          : count - COUNT_W'(1);
   end

   hex_to_7seg u_seg (
      .hex (count),
      .seg (hex_out)
   );

endmodule

// File: tb/tb_up_down_counter.sv
// Bench for up_down_counter: vector table, corner sequences and
// random stimulus against a cycle-counting reference model.
module tb_up_down_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       up_down = 1'b1;
   logic       pause = 1'b0;
   logic [6:0] hex1;
   logic [6:0] hex4;

   int n_vec = 0;
   int n_bad = 0;

   int m_cnt1 = 0;
   int m_cnt4 = 0;
   int m_edges4 = 0;

   logic [6:0] seg_ref [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef struct {
      logic       r;
      logic       u;
      logic       p;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   up_down_counter #(.TICK_DIV(1)) dut1 (
      .clk     (clk),
      .reset   (reset),
      .up_down (up_down),
      .pause   (pause),
      .hex_out (hex1)
   );

   up_down_counter #(.TICK_DIV(4)) dut4 (
      .clk     (clk),
      .reset   (reset),
      .up_down (up_down),
      .pause   (pause),
      .hex_out (hex4)
   );

   function automatic int nxt(int c, logic u);
      return u ? (c + 1) % 16 : (c + 15) % 16;
   endfunction

   task automatic chk(string name, logic [6:0] act,
                      logic [6:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Drive at negedge, model the edge, sample at next negedge.
   task automatic step(logic r, logic u, logic p);
      reset = r;
      up_down = u;
      pause = p;
      @(posedge clk);
      if (r) begin
         m_cnt1 = 0;
         m_cnt4 = 0;
         m_edges4 = 0;
      end else begin
         m_edges4++;
         if (!p)
            m_cnt1 = nxt(m_cnt1, u);
         if (!p && (m_edges4 % 4 == 0))
            m_cnt4 = nxt(m_cnt4, u);
      end
      @(negedge clk);
   endtask

   task automatic chk_model(string tag);
      chk({tag, "/div1"}, hex1, seg_ref[m_cnt1]);
      chk({tag, "/div4"}, hex4, seg_ref[m_cnt4]);
   endtask

   task automatic add(logic r, logic u, logic p, logic [6:0] e);
      vec_t v;
      v.r = r;
      v.u = u;
      v.p = p;
      v.exp = e;
      vecs.push_back(v);
   endtask

   initial begin
      // reset held with up_down=1
      for (int i = 0; i < 5; i++) add(1, 1, 0, 7'h40);
      add(0, 1, 0, 7'h79);
      add(0, 1, 0, 7'h24);
      add(0, 1, 0, 7'h30);
      add(0, 1, 0, 7'h19);
      add(0, 1, 0, 7'h12);
      // direction switch at 5
      add(0, 0, 0, 7'h19);
      add(0, 0, 0, 7'h30);
      add(0, 1, 0, 7'h19);
      add(0, 1, 0, 7'h12);
      add(0, 1, 0, 7'h02);
      add(0, 1, 0, 7'h78);
      // pause at 7
      for (int i = 0; i < 10; i++) add(0, 1, 1, 7'h78);
      add(0, 1, 0, 7'h00);
      // down wrap from reset
      add(1, 0, 0, 7'h40);
      add(0, 0, 0, 7'h0E);
      add(0, 0, 0, 7'h06);
      add(0, 0, 0, 7'h21);

      @(negedge clk);
      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].u, vecs[i].p);
         chk($sformatf("vec%0d", i), hex1, vecs[i].exp);
         chk_model($sformatf("vec%0d", i));
      end

      // up wrap: F on cycle 15, then 0, then 1
      step(1, 1, 0);
      for (int c = 1; c <= 17; c++) begin
         step(0, 1, 0);
         if (c == 15) chk("wrap_f", hex1, 7'h0E);
         if (c == 16) chk("wrap_0", hex1, 7'h40);
         if (c == 17) chk("wrap_1", hex1, 7'h79);
      end

      // div4: reach 9, reset, first increment 4 cycles later
      step(1, 1, 0);
      for (int c = 1; c <= 36; c++) begin
         step(0, 1, 0);
         if (c % 4 == 1)
            chk($sformatf("div4_c%0d", c), hex4,
                seg_ref[(c - 1) / 4]);
      end
      chk("div4_at9", hex4, 7'h10);
      step(1, 0, 1);
      chk("div4_rst", hex4, 7'h40);
      for (int c = 1; c <= 4; c++) begin
         step(0, 1, 0);
         chk($sformatf("div4_rel%0d", c), hex4,
             (c == 4) ? 7'h79 : 7'h40);
      end

      // random against model
      step(1, 1, 0);
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 31) == 0),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0));
         chk_model($sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
